// File: rtl/rsc_frame_if.sv
// Handshake bundle between the bit source, the RSC frame sequencer and the output packer.
// The master modport belongs to the source/packer side; the slave modport belongs to rsc_frame_ctrl.
interface rsc_frame_if #(
    parameter int unsigned LEN_W = 11
);
    logic             start;
    logic [LEN_W-1:0] frame_len;
    logic             in_valid;
    logic             in_bit;
    logic             in_ready;
    logic             out_valid;
    logic             out_sys;
    logic             out_par;
    logic             out_tail;
    logic             out_last;
    logic             out_ready;
    logic             busy;
    logic             len_err;

    modport master (
        output start, frame_len, in_valid, in_bit, out_ready,
        input  in_ready, out_valid, out_sys, out_par, out_tail, out_last, busy, len_err
    );

    modport slave (
        input  start, frame_len, in_valid, in_bit, out_ready,
        output in_ready, out_valid, out_sys, out_par, out_tail, out_last, busy, len_err
    );
endinterface

// File: rtl/rsc_frame_ctrl.sv
// Frame sequencer for the rate-1/2 (1,5/7) RSC encoder: steps the 4-state trellis per data bit.
// Define RSC_TERM_EN to append the two trellis-termination tail steps that return the state to 00.
module rsc_frame_ctrl #(
    parameter int unsigned K_MAX = 1024,
    parameter int unsigned LEN_W = 11
) (
    input logic        clk,
    input logic        rst,
    rsc_frame_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StData, StTail, StFlush} state_e;

    state_e           st_q, st_d;
    logic [1:0]       trel_q, trel_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             busy_q, busy_d;
    logic             len_err_q, len_err_d;
    logic             ov_q, ov_d;
    logic             sys_q, sys_d;
    logic             par_q, par_d;
    logic             tail_q, tail_d;
    logic             last_q, last_d;
`ifdef RSC_TERM_EN
    logic             tail_step_q, tail_step_d;
`endif

    logic slot_free, in_ready, issue, u, fb, tail_flag, last_flag;

    always_comb begin
        st_d      = st_q;
        trel_d    = trel_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        busy_d    = busy_q;
        len_err_d = 1'b0;
        ov_d      = ov_q;
        sys_d     = sys_q;
        par_d     = par_q;
        tail_d    = tail_q;
        last_d    = last_q;
`ifdef RSC_TERM_EN
        tail_step_d = tail_step_q;
`endif
        slot_free = !ov_q || bus.out_ready;
        in_ready  = 1'b0;
        issue     = 1'b0;
        u         = 1'b0;
        tail_flag = 1'b0;
        last_flag = 1'b0;
        fb        = trel_q[1] ^ trel_q[0];

        // Drained slot returns to all-zero unless refilled below.
        if (ov_q && bus.out_ready) begin
            ov_d   = 1'b0;
            sys_d  = 1'b0;
            par_d  = 1'b0;
            tail_d = 1'b0;
            last_d = 1'b0;
        end

        unique case (st_q)
            StIdle: begin
                if (bus.start) begin
                    if (bus.frame_len != '0 && bus.frame_len <= LEN_W'(K_MAX)) begin
                        len_d  = bus.frame_len;
                        cnt_d  = '0;
                        trel_d = 2'b00;
                        busy_d = 1'b1;
                        st_d   = StData;
                    end else begin
                        len_err_d = 1'b1;
                    end
                end
            end
            StData: begin
                in_ready = slot_free;
                if (bus.in_valid && slot_free) begin
                    issue = 1'b1;
                    u     = bus.in_bit;
                    cnt_d = cnt_q + LEN_W'(1);
                    if (cnt_q == len_q - LEN_W'(1)) begin
`ifdef RSC_TERM_EN
                        tail_step_d = 1'b0;
                        st_d        = StTail;
`else
                        last_flag = 1'b1;
                        st_d      = StFlush;
`endif
                    end
                end
            end
`ifdef RSC_TERM_EN
            StTail: begin
                if (slot_free) begin
                    // u = fb zeroes the new r1, so two steps flush the register to 00.
                    issue       = 1'b1;
                    u           = fb;
                    tail_flag   = 1'b1;
                    tail_step_d = 1'b1;
                    if (tail_step_q) begin
                        last_flag = 1'b1;
                        st_d      = StFlush;
                    end
                end
            end
`endif
            StFlush: begin
                if (ov_q && bus.out_ready) begin
                    busy_d = 1'b0;
                    st_d   = StIdle;
                end
            end
            default: st_d = StIdle;
        endcase

        if (issue) begin
            ov_d   = 1'b1;
            sys_d  = u;
            par_d  = u ^ trel_q[1];
            tail_d = tail_flag;
            last_d = last_flag;
            trel_d = {u ^ fb, trel_q[1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q      <= StIdle;
            trel_q    <= 2'b00;
            cnt_q     <= '0;
            len_q     <= '0;
            busy_q    <= 1'b0;
            len_err_q <= 1'b0;
            ov_q      <= 1'b0;
            sys_q     <= 1'b0;
            par_q     <= 1'b0;
            tail_q    <= 1'b0;
            last_q    <= 1'b0;
`ifdef RSC_TERM_EN
            tail_step_q <= 1'b0;
`endif
        end else begin
            st_q      <= st_d;
            trel_q    <= trel_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            busy_q    <= busy_d;
            len_err_q <= len_err_d;
            ov_q      <= ov_d;
            sys_q     <= sys_d;
            par_q     <= par_d;
            tail_q    <= tail_d;
            last_q    <= last_d;
`ifdef RSC_TERM_EN
            tail_step_q <= tail_step_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = ov_q;
    assign bus.out_sys   = sys_q;
    assign bus.out_par   = par_q;
    assign bus.out_tail  = tail_q;
    assign bus.out_last  = last_q;
    assign bus.busy      = busy_q;
    assign bus.len_err   = len_err_q;
endmodule
